// File: rtl/bitslam_mixer.sv
// Two-voice mixer for the bitslam LFSR voices: per-voice volume and mute, master scale,
// then a first-order sigma-delta modulator so one pin carries the mixed level.
module bitslam_mixer #(
  parameter int unsigned VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [1:0]       addr,
  input  logic [5:0]       data,
  input  logic             voice0_in,
  input  logic             voice1_in,
  output logic [VOL_W:0]   level,
  output logic             dac_out
);

  localparam int unsigned L = VOL_W + 1;
  localparam int unsigned P = 2 * VOL_W + 1;

  typedef enum logic [1:0] {
    REG_VOL0   = 2'd0,
    REG_VOL1   = 2'd1,
    REG_MASTER = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  logic [VOL_W-1:0] vol0;
  logic [VOL_W-1:0] vol1;
  logic [VOL_W-1:0] master;
  logic             mute0;
  logic             mute1;

  logic [L-1:0]     mix;
  logic [L-1:0]     acc;

  logic [L-1:0]     term0;
  logic [L-1:0]     term1;
  logic [L-1:0]     mix_next;
  logic [P-1:0]     product;
  logic [L:0]       dsm_sum;

  // Register file: addr 3 is reserved and leaves every register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      vol0   <= '0;
      vol1   <= '0;
      master <= '1;
      mute0  <= 1'b0;
      mute1  <= 1'b0;
    end else if (write_en) begin
      unique case (reg_sel_e'(addr))
        REG_VOL0:   vol0 <= data[VOL_W-1:0];
        REG_VOL1:   vol1 <= data[VOL_W-1:0];
        REG_MASTER: begin
          master <= data[VOL_W-1:0];
          mute0  <= data[4];
          mute1  <= data[5];
        end
        REG_RSVD:   ;
      endcase
    end
  end

  always_comb begin
    term0    = (voice0_in && !mute0) ? L'(vol0) : '0;
    term1    = (voice1_in && !mute1) ? L'(vol1) : '0;
    mix_next = term0 + term1;
    product  = P'(mix) * P'(master);
    dsm_sum  = {1'b0, acc} + {1'b0, level};
  end

  // Carry out of the accumulator is the DAC bit; acc simply wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix     <= '0;
      level   <= '0;
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      mix     <= mix_next;
      level   <= product[P-1:VOL_W];
      acc     <= dsm_sum[L-1:0];
      dac_out <= dsm_sum[L];
    end
  end

endmodule
